// File: rtl/stack_ctrl.sv
// stack_ctrl: eForth stack-primitive sequencer over a push/pop-only stack memory, TOS kept locally.
// Latency: 1 cycle (NOP/PUSH/POP/DROP/DUP/OVER/reject), 2 SWAP, 4 ROT, max(1,depth-1) CLEAR; done on last step.
// Backpressure: cmd_rdy only in IDLE, cmd_vld while busy is ignored. Define STACK_CTRL_HWM_EN for the hwm output.
module stack_ctrl #(
    parameter int DEPTH = 16,
    parameter int DSZ   = 32,
    parameter int SSZ   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_vld,
    output logic           cmd_rdy,
    input  logic [2:0]     cmd_op,
    input  logic           cmd_clr,
    input  logic [DSZ-1:0] cmd_vi,
    output logic           done,
    output logic           err,
    output logic [DSZ-1:0] vo,
    output logic [DSZ-1:0] tos,
    output logic [DSZ-1:0] nos,
    output logic [SSZ:0]   depth,
    output logic           ovf,
    output logic           unf,
`ifdef STACK_CTRL_HWM_EN
    output logic [SSZ:0]   hwm,
`endif
    output logic           ss_push,
    output logic           ss_pop,
    output logic [DSZ-1:0] ss_di,
    input  logic [DSZ-1:0] ss_s0,
    input  logic [DSZ-1:0] ss_s1
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_DROP = 3'd4;
    localparam logic [2:0] OP_SWAP = 3'd5;
    localparam logic [2:0] OP_OVER = 3'd6;
    localparam logic [2:0] OP_ROT  = 3'd7;

    localparam logic [SSZ:0] ZERO  = '0;
    localparam logic [SSZ:0] ONE   = (SSZ+1)'(1);
    localparam logic [SSZ:0] TWO   = (SSZ+1)'(2);
    localparam logic [SSZ:0] THREE = (SSZ+1)'(3);
    localparam logic [SSZ:0] FULL  = (SSZ+1)'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_EXEC, S_ERR, S_SW1, S_SW2,
        S_RT1, S_RT2, S_RT3, S_RT4, S_CLR
    } state_t;

    state_t         state, state_nxt;
    logic [2:0]     op_q;
    logic           clr_q;
    logic [DSZ-1:0] vi_q;
    logic [DSZ-1:0] t1, t2;
    logic [SSZ:0]   cnt;
    logic           accept;
    logic           chk_ovf, chk_unf;
    logic           clr_fin;
    logic [DSZ-1:0] tos_d;
    logic [SSZ:0]   depth_d;

    assign accept = cmd_vld & cmd_rdy;
    assign nos    = ss_s0;

    // Legality of the offered command against the current depth.
    always_comb begin
        chk_ovf = 1'b0;
        chk_unf = 1'b0;
        if (!cmd_clr) begin
            case (cmd_op)
                OP_PUSH:         chk_ovf = (depth == FULL);
                OP_POP, OP_DROP: chk_unf = (depth == ZERO);
                OP_DUP: begin
                    chk_ovf = (depth == FULL);
                    chk_unf = (depth == ZERO);
                end
                OP_SWAP:         chk_unf = (depth < TWO);
                OP_OVER: begin
                    chk_ovf = (depth == FULL);
                    chk_unf = (depth < TWO);
                end
                OP_ROT:          chk_unf = (depth < THREE);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (chk_ovf | chk_unf)     state_nxt = S_ERR;
                    else if (cmd_clr)          state_nxt = (depth > ONE) ? S_CLR : S_EXEC;
                    else if (cmd_op == OP_SWAP) state_nxt = S_SW1;
                    else if (cmd_op == OP_ROT)  state_nxt = S_RT1;
                    else                       state_nxt = S_EXEC;
                end
            end
            S_SW1:   state_nxt = S_SW2;
            S_RT1:   state_nxt = S_RT2;
            S_RT2:   state_nxt = S_RT3;
            S_RT3:   state_nxt = S_RT4;
            S_CLR:   state_nxt = (cnt == ONE) ? S_IDLE : S_CLR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_rdy = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        ss_push = 1'b0;
        ss_pop  = 1'b0;
        ss_di   = tos;
        case (state)
            S_IDLE: cmd_rdy = 1'b1;
            S_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            S_EXEC: begin
                done = 1'b1;
                if (!clr_q) begin
                    case (op_q)
                        OP_PUSH:         ss_push = (depth != ZERO);
                        OP_POP, OP_DROP: ss_pop  = (depth > ONE);
                        OP_DUP, OP_OVER: ss_push = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_SW1, S_RT1, S_RT2: ss_pop = 1'b1;
            S_SW2, S_RT4: begin
                ss_push = 1'b1;
                done    = 1'b1;
            end
            S_RT3: begin
                ss_push = 1'b1;
                ss_di   = t1;
            end
            S_CLR: begin
                ss_pop = 1'b1;
                done   = (cnt == ONE);
            end
            default: ;
        endcase
    end

    assign clr_fin = ((state == S_EXEC) && clr_q) || ((state == S_CLR) && (cnt == ONE));

    // Next TOS/depth; OVER reads ss_s0 before the push edge overwrites the top cell.
    always_comb begin
        tos_d   = tos;
        depth_d = depth;
        case (state)
            S_EXEC: begin
                if (clr_q) begin
                    tos_d   = '0;
                    depth_d = ZERO;
                end else begin
                    case (op_q)
                        OP_PUSH: begin
                            tos_d   = vi_q;
                            depth_d = depth + ONE;
                        end
                        OP_POP, OP_DROP: begin
                            tos_d   = (depth > ONE) ? ss_s0 : '0;
                            depth_d = depth - ONE;
                        end
                        OP_DUP:  depth_d = depth + ONE;
                        OP_OVER: begin
                            tos_d   = ss_s0;
                            depth_d = depth + ONE;
                        end
                        default: ;
                    endcase
                end
            end
            S_SW2: tos_d = t1;
            S_RT4: tos_d = t2;
            S_CLR: begin
                if (cnt == ONE) begin
                    tos_d   = '0;
                    depth_d = ZERO;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tos   <= '0;
            depth <= ZERO;
            vo    <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            op_q  <= OP_NOP;
            clr_q <= 1'b0;
            vi_q  <= '0;
            t1    <= '0;
            t2    <= '0;
            cnt   <= ZERO;
        end else begin
            tos   <= tos_d;
            depth <= depth_d;
            if (accept) begin
                op_q  <= cmd_op;
                clr_q <= cmd_clr;
                vi_q  <= cmd_vi;
                cnt   <= depth - ONE;
                if (chk_ovf) ovf <= 1'b1;
                if (chk_unf) unf <= 1'b1;
                // Loading vo at acceptance makes it valid in the done cycle.
                if (!cmd_clr && (cmd_op == OP_POP) && !chk_unf) vo <= tos;
            end
            if (clr_fin) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (state == S_CLR) cnt <= cnt - ONE;
            if (state == S_SW1) t1 <= ss_s0;
            // a is already visible as the second cell before the first pop.
            if (state == S_RT1) begin
                t1 <= ss_s0;
                t2 <= ss_s1;
            end
        end
    end

`ifdef STACK_CTRL_HWM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                hwm <= ZERO;
        else if (clr_fin)        hwm <= ZERO;
        else if (depth_d > hwm)  hwm <= depth_d;
    end
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: table vectors, directed corner sequences and random commands against a queue-based stack model.
// A behavioural push/pop memory with DEPTH-1 cells serves the ss_* side.
module tb_stack_ctrl;
    localparam int DEPTH = 16;
    localparam int DSZ   = 32;
    localparam int SSZ   = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cmd_vld = 1'b0;
    logic           cmd_rdy;
    logic [2:0]     cmd_op = 3'd0;
    logic           cmd_clr = 1'b0;
    logic [DSZ-1:0] cmd_vi = '0;
    logic           done, err, ovf, unf, ss_push, ss_pop;
    logic [DSZ-1:0] vo, tos, nos, ss_di, ss_s0, ss_s1;
    logic [SSZ:0]   depth;
`ifdef STACK_CTRL_HWM_EN
    logic [SSZ:0]   hwm;
`endif

    stack_ctrl #(.DEPTH(DEPTH), .DSZ(DSZ), .SSZ(SSZ)) dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
        .cmd_clr(cmd_clr), .cmd_vi(cmd_vi), .done(done), .err(err), .vo(vo), .tos(tos),
        .nos(nos), .depth(depth), .ovf(ovf), .unf(unf),
`ifdef STACK_CTRL_HWM_EN
        .hwm(hwm),
`endif
        .ss_push(ss_push), .ss_pop(ss_pop), .ss_di(ss_di), .ss_s0(ss_s0), .ss_s1(ss_s1)
    );

    always #5 clk = ~clk;

    // Stack memory model, pointer reset by the same rst.
    logic [DSZ-1:0] mem [0:DEPTH-2];
    int ptr = 0;
    int n_push = 0, n_pop = 0, n_both = 0, mem_bad = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) ptr <= 0;
        else begin
            if (ss_push) begin
                if (ptr >= DEPTH-1) mem_bad <= mem_bad + 1;
                else begin mem[ptr] <= ss_di; ptr <= ptr + 1; end
            end
            if (ss_pop) begin
                if (ptr == 0) mem_bad <= mem_bad + 1;
                else ptr <= ptr - 1;
            end
        end
    end
    always @(posedge clk) begin
        if (ss_push) n_push <= n_push + 1;
        if (ss_pop)  n_pop  <= n_pop + 1;
        if (ss_push && ss_pop) n_both <= n_both + 1;
    end
    always_comb begin
        ss_s0 = (ptr > 0) ? mem[ptr-1] : '0;
        ss_s1 = (ptr > 1) ? mem[ptr-2] : '0;
    end

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Reference model: the whole logical stack, top at the back.
    logic [DSZ-1:0] mdl [$];
    logic           m_ovf = 1'b0, m_unf = 1'b0;
    logic [DSZ-1:0] m_vo = '0;
    int             m_hwm = 0;

    task automatic model_reset();
        mdl.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_vo = '0; m_hwm = 0;
    endtask

    task automatic model_apply(input logic [2:0] op, input logic clr, input logic [DSZ-1:0] vi,
                               output logic e, output int cyc, output int pu, output int po);
        int d;
        logic [DSZ-1:0] a;
        d = mdl.size(); e = 1'b0; cyc = 1; pu = 0; po = 0;
        if (clr) begin
            cyc = (d > 1) ? d - 1 : 1;
            po  = (d > 1) ? d - 1 : 0;
            mdl.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_hwm = 0;
        end else begin
            case (op)
                3'd1: if (d == DEPTH) begin e = 1; m_ovf = 1; end
                      else begin pu = (d > 0); mdl.push_back(vi); end
                3'd2, 3'd4: if (d == 0) begin e = 1; m_unf = 1; end
                      else begin
                          if (op == 3'd2) m_vo = mdl[d-1];
                          po = (d > 1);
                          void'(mdl.pop_back());
                      end
                3'd3: if (d == DEPTH) begin e = 1; m_ovf = 1; end
                      else if (d == 0) begin e = 1; m_unf = 1; end
                      else begin pu = 1; mdl.push_back(mdl[d-1]); end
                3'd5: if (d < 2) begin e = 1; m_unf = 1; end
                      else begin
                          cyc = 2; pu = 1; po = 1;
                          a = mdl[d-1]; mdl[d-1] = mdl[d-2]; mdl[d-2] = a;
                      end
                3'd6: if (d == DEPTH) begin e = 1; m_ovf = 1; end
                      else if (d < 2) begin e = 1; m_unf = 1; end
                      else begin pu = 1; mdl.push_back(mdl[d-2]); end
                3'd7: if (d < 3) begin e = 1; m_unf = 1; end
                      else begin
                          cyc = 4; pu = 2; po = 2;
                          a = mdl[d-3]; mdl.delete(d-3); mdl.push_back(a);
                      end
                default: ;
            endcase
        end
        if (e) begin cyc = 1; pu = 0; po = 0; end
        if (mdl.size() > m_hwm) m_hwm = mdl.size();
    endtask

    // Issue one command from a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic run_cmd(input logic [2:0] op, input logic clr, input logic [DSZ-1:0] vi, input bit hold,
                           output int cyc, output logic e, output logic [DSZ-1:0] v);
        chk("rdy_idle", cmd_rdy, 1);
        cmd_vld = 1'b1; cmd_op = op; cmd_clr = clr; cmd_vi = vi;
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        chk("rdy_busy", cmd_rdy, 0);
        if (hold) begin
            cmd_op = 3'($urandom); cmd_clr = 1'b0; cmd_vi = $urandom;
        end else cmd_vld = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        cmd_vld = 1'b0;
        e = err; v = vo;
        @(negedge clk);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic clr, input logic [DSZ-1:0] vi, input bit hold,
                          output int cyc, output logic e);
        logic x_e; int x_cyc, x_pu, x_po, p0, q0, sz;
        logic [DSZ-1:0] v;
        p0 = n_push; q0 = n_pop;
        model_apply(op, clr, vi, x_e, x_cyc, x_pu, x_po);
        run_cmd(op, clr, vi, hold, cyc, e, v);
        sz = mdl.size();
        chk("cycles", 64'(cyc), 64'(x_cyc));
        chk("err", e, x_e);
        if (!clr && op == 3'd2 && !x_e) chk("vo_with_done", v, m_vo);
        chk("vo", vo, m_vo);
        chk("depth", depth, 64'(sz));
        chk("tos", tos, (sz > 0) ? mdl[sz-1] : '0);
        if (sz >= 2) chk("nos", nos, mdl[sz-2]);
        chk("ovf", ovf, m_ovf);
        chk("unf", unf, m_unf);
        chk("n_push", 64'(n_push - p0), 64'(x_pu));
        chk("n_pop", 64'(n_pop - q0), 64'(x_po));
        chk("mem_ptr", 64'(ptr), 64'((sz > 0) ? sz - 1 : 0));
        chk("strobe_both", 64'(n_both), 0);
        chk("mem_bad", 64'(mem_bad), 0);
`ifdef STACK_CTRL_HWM_EN
        chk("hwm", hwm, 64'(m_hwm));
`endif
    endtask

    typedef struct {
        logic [2:0]     op;
        logic           clr;
        logic [DSZ-1:0] vi;
        logic           e;
        logic [DSZ-1:0] tos;
        int             dep;
        int             cyc;
    } vec_t;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [20];
        int cyc;
        logic e;
        tbl = '{
            '{3'd2, 1'b0, 32'd0, 1'b1, 32'd0, 0, 1},
            '{3'd1, 1'b0, 32'd7, 1'b0, 32'd7, 1, 1},
            '{3'd2, 1'b0, 32'd0, 1'b0, 32'd0, 0, 1},
            '{3'd1, 1'b0, 32'd5, 1'b0, 32'd5, 1, 1},
            '{3'd1, 1'b0, 32'd9, 1'b0, 32'd9, 2, 1},
            '{3'd6, 1'b0, 32'd0, 1'b0, 32'd5, 3, 1},
            '{3'd3, 1'b0, 32'd0, 1'b0, 32'd5, 4, 1},
            '{3'd0, 1'b1, 32'd0, 1'b0, 32'd0, 0, 3},
            '{3'd1, 1'b0, 32'd1, 1'b0, 32'd1, 1, 1},
            '{3'd1, 1'b0, 32'd2, 1'b0, 32'd2, 2, 1},
            '{3'd1, 1'b0, 32'd3, 1'b0, 32'd3, 3, 1},
            '{3'd5, 1'b0, 32'd0, 1'b0, 32'd2, 3, 2},
            '{3'd5, 1'b0, 32'd0, 1'b0, 32'd3, 3, 2},
            '{3'd7, 1'b0, 32'd0, 1'b0, 32'd1, 3, 4},
            '{3'd7, 1'b0, 32'd0, 1'b0, 32'd2, 3, 4},
            '{3'd4, 1'b0, 32'd0, 1'b0, 32'd1, 2, 1},
            '{3'd7, 1'b0, 32'd0, 1'b1, 32'd1, 2, 1},
            '{3'd0, 1'b0, 32'd0, 1'b0, 32'd1, 2, 1},
            '{3'd0, 1'b1, 32'd0, 1'b0, 32'd0, 0, 1},
            '{3'd3, 1'b0, 32'd0, 1'b1, 32'd0, 0, 1}
        };

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        chk("rst_tos", tos, 0);   chk("rst_depth", depth, 0); chk("rst_vo", vo, 0);
        chk("rst_ovf", ovf, 0);   chk("rst_unf", unf, 0);     chk("rst_done", done, 0);
        chk("rst_err", err, 0);   chk("rst_push", ss_push, 0); chk("rst_pop", ss_pop, 0);
        chk("rst_rdy", cmd_rdy, 1);
        rst = 1'b1;
        @(negedge clk);
        model_reset();

        for (int i = 0; i < 20; i++) begin
            do_cmd(tbl[i].op, tbl[i].clr, tbl[i].vi, 1'b0, cyc, e);
            chk("tbl_err", e, tbl[i].e);
            chk("tbl_tos", tos, tbl[i].tos);
            chk("tbl_depth", depth, 64'(tbl[i].dep));
            chk("tbl_cycles", 64'(cyc), 64'(tbl[i].cyc));
        end

        // Asynchronous reset in RT2 of a ROT.
        for (int i = 1; i <= 3; i++) do_cmd(3'd1, 1'b0, DSZ'(i), 1'b0, cyc, e);
        cmd_vld = 1'b1; cmd_op = 3'd7; cmd_clr = 1'b0;
        @(posedge clk); @(negedge clk);
        cmd_vld = 1'b0;
        @(negedge clk);
        chk("rt2_pop", ss_pop, 1);
        rst = 1'b0;
        #1;
        chk("mid_tos", tos, 0);    chk("mid_depth", depth, 0); chk("mid_pop", ss_pop, 0);
        chk("mid_push", ss_push, 0); chk("mid_done", done, 0);  chk("mid_rdy", cmd_rdy, 1);
        chk("mid_ptr", 64'(ptr), 0);
        model_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        chk("post_rdy", cmd_rdy, 1);
        chk("post_depth", depth, 0);

        // Fill to capacity, then the boundary rejections.
        for (int i = 0; i < DEPTH; i++) do_cmd(3'd1, 1'b0, DSZ'(1000 + i), 1'b0, cyc, e);
        chk("full_depth", depth, 16); chk("full_tos", tos, 1015); chk("full_nos", nos, 1014);
        do_cmd(3'd1, 1'b0, 32'd1016, 1'b0, cyc, e);
        chk("full_push_err", e, 1); chk("full_ovf", ovf, 1); chk("full_push_tos", tos, 1015);
        do_cmd(3'd3, 1'b0, 32'd0, 1'b0, cyc, e);
        chk("full_dup_err", e, 1);
        do_cmd(3'd6, 1'b0, 32'd0, 1'b1, cyc, e);
        chk("full_over_err", e, 1);
        for (int i = 0; i < 6; i++) do_cmd(3'd2, 1'b0, 32'd0, 1'b0, cyc, e);
        chk("pre_clr_depth", depth, 10);
        do_cmd(3'd0, 1'b1, 32'd0, 1'b0, cyc, e);
        chk("clr_cycles", 64'(cyc), 9); chk("clr_depth", depth, 0); chk("clr_ptr", 64'(ptr), 0);
        chk("clr_ovf", ovf, 0);
        do_cmd(3'd1, 1'b0, 32'd42, 1'b0, cyc, e);
        chk("push42_tos", tos, 42);
`ifdef STACK_CTRL_HWM_EN
        chk("push42_hwm", hwm, 1);
`endif

        // Random commands; half of them keep cmd_vld asserted while busy.
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [2:0] op;
            r  = int'($urandom_range(0, 15));
            op = (r < 6) ? 3'd1 : 3'($urandom_range(0, 7));
            do_cmd(op, (r == 15), $urandom, 1'($urandom_range(0, 1)), cyc, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
